// File: rtl/uart_frame_pkg.sv
// Shared types and defaults for the UART frame parser.
//   state_e : parser FSM states (HUNT, LEN, PAYLOAD, CHECK, EMIT)
//   cause_e : error cause reported on error_cause
//   SYNC_DEFAULT / WIDTH_DEFAULT / MAX_PAYLOAD_DEFAULT : parameter defaults
//   addr_bits() : address width for a register array of a given depth
package uart_frame_pkg;

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_LEN,
      ST_PAYLOAD,
      ST_CHECK,
      ST_EMIT
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_BAD_LEN = 2'd1,
      CAUSE_BAD_CHK = 2'd2
   } cause_e;

   localparam int         WIDTH_DEFAULT       = 8;
   localparam int         MAX_PAYLOAD_DEFAULT = 16;
   localparam logic [7:0] SYNC_DEFAULT        = 8'hA5;

   // A depth-1 array still needs a one-bit address.
   function automatic int addr_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Stream bundle between the UART receive buffer, the frame parser and the
// payload consumer.
//   in_data/in_valid/in_ready     : received word stream into the parser
//   out_data/out_valid/out_ready  : verified payload stream out of the parser
//   out_last                      : final payload word of a frame
// master : the environment around the parser (drives input, accepts output)
// slave  : the parser itself
interface uart_frame_parser_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_last
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_last
   );
endinterface

// File: rtl/frame_payload_buf.sv
// Payload storage for one frame: DEPTH x WIDTH register array.
//   clock   : write clock
//   wr_en   : write wr_data at addr on the rising edge
//   addr    : shared write/read address (the parser's index)
//   wr_data : word to store
//   rd_data : combinational read of the word at addr
// Contents are not reset; the parser never reads a slot before writing it.
module frame_payload_buf
   import uart_frame_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int DEPTH = MAX_PAYLOAD_DEFAULT,
   parameter int AW    = addr_bits(DEPTH)
) (
   input  logic             clock,
   input  logic             wr_en,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) mem_q[addr] <= wr_data;
   end

   assign rd_data = mem_q[addr];

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser behind the UART receive buffer.
// Frame format: SYNC, LEN, LEN payload words, CHK. A frame is good when
// LEN + payload + CHK wraps to zero. Good payloads are replayed on the
// output stream with out_last on the final word; bad frames are dropped,
// flagged with a one-cycle frame_error, and counted.
//   clock, resetn : rising-edge clock, asynchronous active-low reset
//   bus           : input/output streams (slave side)
//   frame_ok      : one-cycle pulse after an accepted CHK that verifies
//   frame_error   : one-cycle pulse after a rejected LEN or CHK
//   error_cause   : cause of the most recent error (held)
//   error_count   : dropped frames, saturating at all-ones
module uart_frame_parser
   import uart_frame_pkg::*;
#(
   parameter int               WIDTH       = WIDTH_DEFAULT,
   parameter int               MAX_PAYLOAD = MAX_PAYLOAD_DEFAULT,
   parameter logic [WIDTH-1:0] SYNC_WORD   = WIDTH'(SYNC_DEFAULT)
) (
   input  logic                clock,
   input  logic                resetn,
   uart_frame_parser_if.slave  bus,
   output logic                frame_ok,
   output logic                frame_error,
   output logic [1:0]          error_cause,
   output logic [7:0]          error_count
);

   localparam int LW = $clog2(MAX_PAYLOAD + 1);
   localparam int AW = addr_bits(MAX_PAYLOAD);
   // One extra bit so the length limit is comparable for any WIDTH.
   localparam logic [WIDTH:0] MAX_LEN = (WIDTH+1)'(MAX_PAYLOAD);

   state_e           state_q, state_d;
   logic [LW-1:0]    idx_q, idx_d;
   logic [LW-1:0]    len_q, len_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             frame_ok_q, frame_ok_d;
   logic             frame_error_q, frame_error_d;
   cause_e           cause_q, cause_d;
   logic [7:0]       count_q, count_d;

   logic             in_fire, out_fire;
   logic             len_bad;
   logic             at_last;
   logic [WIDTH-1:0] chk_sum;
   logic             buf_wr_en;
   logic [WIDTH-1:0] buf_rd_data;

   frame_payload_buf #(
      .WIDTH (WIDTH),
      .DEPTH (MAX_PAYLOAD),
      .AW    (AW)
   ) u_buf (
      .clock   (clock),
      .wr_en   (buf_wr_en),
      .addr    (idx_q[AW-1:0]),
      .wr_data (bus.in_data),
      .rd_data (buf_rd_data)
   );

   // Stream outputs come straight from state and the buffer read port; idx
   // only moves on an accepted output word, so data/last hold while stalled.
   assign bus.in_ready  = (state_q != ST_EMIT);
   assign bus.out_valid = (state_q == ST_EMIT);
   assign bus.out_data  = (state_q == ST_EMIT) ? buf_rd_data : '0;
   assign bus.out_last  = (state_q == ST_EMIT) && at_last;

   assign frame_ok    = frame_ok_q;
   assign frame_error = frame_error_q;
   assign error_cause = cause_q;
   assign error_count = count_q;

   assign in_fire  = bus.in_valid && bus.in_ready;
   assign out_fire = bus.out_valid && bus.out_ready;
   assign len_bad  = (bus.in_data == '0) || ({1'b0, bus.in_data} > MAX_LEN);
   assign at_last  = (idx_q == len_q - LW'(1));
   assign chk_sum  = sum_q + bus.in_data;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_HUNT;
         idx_q         <= '0;
         len_q         <= '0;
         sum_q         <= '0;
         frame_ok_q    <= 1'b0;
         frame_error_q <= 1'b0;
         cause_q       <= CAUSE_NONE;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         len_q         <= len_d;
         sum_q         <= sum_d;
         frame_ok_q    <= frame_ok_d;
         frame_error_q <= frame_error_d;
         cause_q       <= cause_d;
         count_q       <= count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      len_d         = len_q;
      sum_d         = sum_q;
      frame_ok_d    = 1'b0;
      frame_error_d = 1'b0;
      cause_d       = cause_q;
      count_d       = count_q;
      buf_wr_en     = 1'b0;

      unique case (state_q)
         ST_HUNT: begin
            if (in_fire && (bus.in_data == SYNC_WORD)) state_d = ST_LEN;
         end

         ST_LEN: begin
            if (in_fire) begin
               if (len_bad) begin
                  frame_error_d = 1'b1;
                  cause_d       = CAUSE_BAD_LEN;
                  state_d       = ST_HUNT;
               end else begin
                  len_d   = bus.in_data[LW-1:0];
                  sum_d   = bus.in_data;   // checksum covers LEN itself
                  idx_d   = '0;
                  state_d = ST_PAYLOAD;
               end
            end
         end

         ST_PAYLOAD: begin
            if (in_fire) begin
               buf_wr_en = 1'b1;
               sum_d     = sum_q + bus.in_data;
               idx_d     = idx_q + LW'(1);
               if (at_last) state_d = ST_CHECK;
            end
         end

         ST_CHECK: begin
            if (in_fire) begin
               idx_d = '0;   // rewind so EMIT starts at buf[0]
               if (chk_sum == '0) begin
                  frame_ok_d = 1'b1;
                  state_d    = ST_EMIT;
               end else begin
                  frame_error_d = 1'b1;
                  cause_d       = CAUSE_BAD_CHK;
                  state_d       = ST_HUNT;
               end
            end
         end

         ST_EMIT: begin
            if (out_fire) begin
               if (at_last) begin
                  idx_d   = '0;
                  state_d = ST_HUNT;
               end else begin
                  idx_d = idx_q + LW'(1);
               end
            end
         end

         default: state_d = ST_HUNT;
      endcase

      if (frame_error_d && (count_q != 8'hFF)) count_d = count_q + 8'd1;
   end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser. A frame-level model (a queue of
// the words since the last sync) predicts pulses, cause, count and the
// expected output word queue; a negedge process compares every cycle.
// Directed frames below also carry literal expectations.
module tb_uart_frame_parser;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } ow_t;

   logic       clock;
   logic       resetn;
   logic       frame_ok;
   logic       frame_error;
   logic [1:0] error_cause;
   logic [7:0] error_count;

   uart_frame_parser_if #(.WIDTH(8)) bus ();

   uart_frame_parser #(
      .WIDTH       (8),
      .MAX_PAYLOAD (16),
      .SYNC_WORD   (8'hA5)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .bus         (bus),
      .frame_ok    (frame_ok),
      .frame_error (frame_error),
      .error_cause (error_cause),
      .error_count (error_count)
   );

   int checks = 0;
   int errors = 0;

   // model state
   logic [7:0] frm[$];
   ow_t        exp_q[$];
   logic       ok_pend, err_pend;
   int         m_cause, m_count;

   // observation for literal checks
   ow_t got[$];
   int  ok_seen, err_seen;
   logic toggle_mode;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_error(input int cause);
      err_pend = 1'b1;
      m_cause  = cause;
      if (m_count < 255) m_count++;
   endfunction

   // Frame-level reference: collect words from a sync, decide at LEN and at
   // the word whose position completes SYNC+LEN+payload+CHK.
   function automatic void model_accept(input logic [7:0] w);
      int len, sum;
      if (frm.size() == 0) begin
         if (w == 8'hA5) frm.push_back(w);
         return;
      end
      frm.push_back(w);
      len = int'(frm[1]);
      if (frm.size() == 2) begin
         if (len == 0 || len > 16) begin
            model_error(1);
            frm.delete();
         end
      end else if (frm.size() == len + 3) begin
         sum = 0;
         for (int i = 1; i < frm.size(); i++) sum += int'(frm[i]);
         if ((sum % 256) == 0) begin
            ok_pend = 1'b1;
            for (int i = 2; i < frm.size() - 1; i++)
               exp_q.push_back('{d: frm[i], l: (i == frm.size() - 2)});
         end else begin
            model_error(2);
         end
         frm.delete();
      end
   endfunction

   // out_ready: held high, or toggled every cycle for back-pressure tests
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         bus.out_ready = toggle_mode ? ~bus.out_ready : 1'b1;
      end
   end

   // compare process
   initial begin
      logic       prev_stall;
      logic [7:0] prev_data;
      logic       prev_last;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      ok_pend = 0; err_pend = 0; m_cause = 0; m_count = 0;
      forever begin
         @(negedge clock);
         if (!resetn) begin
            frm.delete(); exp_q.delete();
            ok_pend = 0; err_pend = 0; m_cause = 0; m_count = 0;
            prev_stall = 1'b0;
            chk("rst_out_valid", bus.out_valid, 1'b0);
            chk("rst_in_ready", bus.in_ready, 1'b1);
            chk("rst_error_count", error_count, 8'd0);
         end else begin
            chk("out_valid", bus.out_valid, exp_q.size() != 0);
            chk("in_ready", bus.in_ready, exp_q.size() == 0);
            if (bus.out_valid && exp_q.size() != 0) begin
               chk("out_data", bus.out_data, exp_q[0].d);
               chk("out_last", bus.out_last, exp_q[0].l);
            end
            if (prev_stall) begin
               chk("hold_valid", bus.out_valid, 1'b1);
               chk("hold_data", bus.out_data, prev_data);
               chk("hold_last", bus.out_last, prev_last);
            end
            chk("frame_ok", frame_ok, ok_pend);
            chk("frame_error", frame_error, err_pend);
            chk("error_cause", error_cause, m_cause);
            chk("error_count", error_count, m_count);
            if (frame_ok) ok_seen++;
            if (frame_error) err_seen++;

            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            ok_pend  = 1'b0;
            err_pend = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
               got.push_back('{d: bus.out_data, l: bus.out_last});
               if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) model_accept(bus.in_data);
         end
      end
   end

   task automatic send(input logic [7:0] b);
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      for (int t = 0; ; t++) begin
         @(negedge clock);
         if (bus.in_ready) break;
         if (t > 200) begin
            chk("send_timeout", 32'd1, 32'd0);
            bus.in_valid = 1'b0;
            return;
         end
      end
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      repeat (2) @(negedge clock);
      for (int t = 0; ; t++) begin
         if (!bus.out_valid && bus.in_ready) break;
         if (t > 200) begin
            chk("drain_timeout", 32'd1, 32'd0);
            break;
         end
         @(negedge clock);
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      resetn       = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      toggle_mode  = 1'b0;
      ok_seen = 0; err_seen = 0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_in_ready", bus.in_ready, 1'b1);
      chk("reset_out_valid", bus.out_valid, 1'b0);
      chk("reset_out_last", bus.out_last, 1'b0);
      chk("reset_out_data", bus.out_data, 8'h00);
      chk("reset_frame_ok", frame_ok, 1'b0);
      chk("reset_frame_error", frame_error, 1'b0);
      chk("reset_error_cause", error_cause, 2'd0);
      chk("reset_error_count", error_count, 8'd0);
      resetn = 1'b1;
      @(posedge clock);
      #1;

      // good frame: 03+11+22+33+97 = 0x100
      send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h97);
      drain();
      chk("good_count", got.size(), 3);
      if (got.size() == 3) begin
         chk("good_w0", {got[0].d, got[0].l}, {8'h11, 1'b0});
         chk("good_w1", {got[1].d, got[1].l}, {8'h22, 1'b0});
         chk("good_w2", {got[2].d, got[2].l}, {8'h33, 1'b1});
      end
      chk("good_ok_pulses", ok_seen, 1);
      chk("good_err_count", error_count, 8'd0);
      got.delete(); ok_seen = 0;

      // bad checksum: 02+10+20+00 = 0x32
      send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
      drain();
      chk("badchk_err_pulses", err_seen, 1);
      chk("badchk_cause", error_cause, 2'd2);
      chk("badchk_count", error_count, 8'd1);
      chk("badchk_no_output", got.size(), 0);
      // single-word frame: 01+7F+80 = 0x100
      send(8'hA5); send(8'h01); send(8'h7F); send(8'h80);
      drain();
      chk("single_count", got.size(), 1);
      if (got.size() == 1) chk("single_w0", {got[0].d, got[0].l}, {8'h7F, 1'b1});
      got.delete(); err_seen = 0;

      // length violations, then a good frame (02+01+02+FB = 0x100)
      send(8'hA5); send(8'h00);
      drain();
      chk("len0_cause", error_cause, 2'd1);
      chk("len0_count", error_count, 8'd2);
      send(8'hA5); send(8'h11);
      drain();
      chk("len17_cause", error_cause, 2'd1);
      chk("len17_count", error_count, 8'd3);
      chk("len_err_pulses", err_seen, 2);
      send(8'hA5); send(8'h02); send(8'h01); send(8'h02); send(8'hFB);
      drain();
      chk("after_len_count", got.size(), 2);
      if (got.size() == 2) chk("after_len_w1", {got[1].d, got[1].l}, {8'h02, 1'b1});
      got.delete();

      // garbage, sync-as-data, back-pressure: 02+A5+A5+B4 = 0x200
      toggle_mode = 1'b1;
      send(8'h00); send(8'hFF); send(8'hA5); send(8'h02); send(8'hA5); send(8'hA5); send(8'hB4);
      drain();
      toggle_mode = 1'b0;
      chk("bp_count", got.size(), 2);
      if (got.size() == 2) begin
         chk("bp_w0", {got[0].d, got[0].l}, {8'hA5, 1'b0});
         chk("bp_w1", {got[1].d, got[1].l}, {8'hA5, 1'b1});
      end
      got.delete();

      // reset mid-payload, then a clean frame: 02+05+06+F3 = 0x100
      send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
      #3 resetn = 1'b0;
      #1;
      chk("midrst_in_ready", bus.in_ready, 1'b1);
      chk("midrst_error_count", error_count, 8'd0);
      chk("midrst_error_cause", error_cause, 2'd0);
      @(posedge clock);
      #1 resetn = 1'b1;
      send(8'hA5); send(8'h02); send(8'h05); send(8'h06); send(8'hF3);
      drain();
      chk("postrst_count", got.size(), 2);
      if (got.size() == 2) begin
         chk("postrst_w0", {got[0].d, got[0].l}, {8'h05, 1'b0});
         chk("postrst_w1", {got[1].d, got[1].l}, {8'h06, 1'b1});
      end
      chk("postrst_err_count", error_count, 8'd0);
      got.delete();

      // saturation: 260 zero-length frames
      for (int i = 0; i < 260; i++) begin
         send(8'hA5); send(8'h00);
      end
      drain();
      chk("sat_count", error_count, 8'd255);
      chk("sat_cause", error_cause, 2'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
